// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus CPU datapath: data width,
// register count, ALU opcodes and the bus-source priority order.
package datapath_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 16;

    // ALU opcodes (any other code produces a zero result)
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_AND  = 5'b01100;
    localparam logic [4:0] OP_OR   = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;

    // Bus sources, highest priority first. The enum value is the bit
    // position of that source's drive strobe in the top-level select vector.
    typedef enum logic [4:0] {
        SRC_R0, SRC_R1, SRC_R2, SRC_R3, SRC_R4, SRC_R5, SRC_R6, SRC_R7,
        SRC_R8, SRC_R9, SRC_R10, SRC_R11, SRC_R12, SRC_R13, SRC_R14, SRC_R15,
        SRC_HI, SRC_LO, SRC_ZHIGH, SRC_ZLOW, SRC_PC, SRC_MDR, SRC_INPORT, SRC_C
    } bus_src_e;

    localparam int NUM_SRC = 24;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: operand A comes from Y, operand B from the bus.
// Produces a double-width result; only MUL and DIV use the upper half.
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [4:0]         OP,
    input  logic               IncPC,
    output logic [2*WIDTH-1:0] R
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [4:0]                shamt;
    logic [2*WIDTH-1:0]        rot_r;
    logic [2*WIDTH-1:0]        rot_l;
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]          quo;
    logic [WIDTH-1:0]          rem;

    assign shamt = B[4:0];
    // Rotates shift a doubled copy of A so a zero amount needs no special case
    assign rot_r = {A, A} >> shamt;
    assign rot_l = {A, A} << shamt;
    assign a_ext = {{WIDTH{A[WIDTH-1]}}, A};
    assign b_ext = {{WIDTH{B[WIDTH-1]}}, B};
    assign prod  = a_ext * b_ext;

    // Signed divide with the two cases that native division leaves undefined
    always_comb begin
        quo = '0;
        rem = '0;
        if (B == '0) begin
            quo = '1;
            rem = A;
        end else if (A == MIN_NEG && B == '1) begin
            quo = MIN_NEG;
            rem = '0;
        end else begin
            quo = $signed(A) / $signed(B);
            rem = $signed(A) % $signed(B);
        end
    end

    // Opcode decode; IncPC overrides the opcode for PC increment
    always_comb begin
        R = '0;
        if (IncPC) begin
            R[WIDTH-1:0] = B + ONE;
        end else begin
            case (OP)
                OP_ADD:  R[WIDTH-1:0] = A + B;
                OP_SUB:  R[WIDTH-1:0] = A - B;
                OP_SHR:  R[WIDTH-1:0] = A >> shamt;
                OP_SHRA: R[WIDTH-1:0] = $unsigned($signed(A) >>> shamt);
                OP_SHL:  R[WIDTH-1:0] = A << shamt;
                OP_ROR:  R[WIDTH-1:0] = rot_r[WIDTH-1:0];
                OP_ROL:  R[WIDTH-1:0] = rot_l[2*WIDTH-1:WIDTH];
                OP_AND:  R[WIDTH-1:0] = A & B;
                OP_OR:   R[WIDTH-1:0] = A | B;
                OP_MUL:  R = prod;
                OP_DIV:  R = {rem, quo};
                OP_NEG:  R[WIDTH-1:0] = '0 - B;
                OP_NOT:  R[WIDTH-1:0] = ~B;
                default: R = '0;
            endcase
        end
    end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: register file, special registers,
// priority bus multiplexer and ALU, driven by one-hot control strobes.
// Optional debug outputs (live bus, MAR, OutPort register) are added
// when DATAPATH_DEBUG_EN is defined.
module datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int NREGS = NUM_REGS
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             R0in,
    input  logic             R1in,
    input  logic             R2in,
    input  logic             R3in,
    input  logic             R4in,
    input  logic             R5in,
    input  logic             R6in,
    input  logic             R7in,
    input  logic             R8in,
    input  logic             R9in,
    input  logic             R10in,
    input  logic             R11in,
    input  logic             R12in,
    input  logic             R13in,
    input  logic             R14in,
    input  logic             R15in,
    input  logic             PCin,
    input  logic             IRin,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             ZHighin,
    input  logic             ZLowin,
    input  logic             MARin,
    input  logic             MDRin,
    input  logic             OutPort,
    input  logic             Cin,
    input  logic             Yin,
    input  logic             R0out,
    input  logic             R1out,
    input  logic             R2out,
    input  logic             R3out,
    input  logic             R4out,
    input  logic             R5out,
    input  logic             R6out,
    input  logic             R7out,
    input  logic             R8out,
    input  logic             R9out,
    input  logic             R10out,
    input  logic             R11out,
    input  logic             R12out,
    input  logic             R13out,
    input  logic             R14out,
    input  logic             R15out,
    input  logic             PCout,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             ZHighout,
    input  logic             ZLowout,
    input  logic             MDRout,
    input  logic             InPort,
    input  logic             Cout,
    input  logic             Read,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic             IncPC,
    input  logic [4:0]       OP
`ifdef DATAPATH_DEBUG_EN
    ,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] MAR_q,
    output logic [WIDTH-1:0] OutPort_q
`endif
);

    logic [WIDTH-1:0]   R [NREGS];
    logic [WIDTH-1:0]   PC, IR, HI, LO, Y, ZHigh, ZLow, MAR, MDR, C;
    logic [WIDTH-1:0]   InPort_reg, OutPort_reg;

    logic [NREGS-1:0]   r_in, r_out;
    logic [NUM_SRC-1:0] src_sel;
    logic [WIDTH-1:0]   src_val [NUM_SRC];
    logic [WIDTH-1:0]   bus, mdr_mux, c_sext;
    logic [2*WIDTH-1:0] alu_r;
    logic               unused_bits;

    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

    // Bit order matches bus_src_e, so bit 0 is the highest-priority source
    assign src_sel = {Cout, InPort, MDRout, PCout, ZLowout, ZHighout, LOout, HIout, r_out};

    assign mdr_mux = Read ? Mdatain : bus;
    assign c_sext  = {{(WIDTH-19){IR[18]}}, IR[18:0]};

    // IR upper bits, MAR and OutPort are only observed externally
    assign unused_bits = ^{IR[WIDTH-1:19], MAR, OutPort_reg};

    // Gather bus source values indexed by priority position
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            src_val[i] = R[i];
        end
        src_val[SRC_HI]     = HI;
        src_val[SRC_LO]     = LO;
        src_val[SRC_ZHIGH]  = ZHigh;
        src_val[SRC_ZLOW]   = ZLow;
        src_val[SRC_PC]     = PC;
        src_val[SRC_MDR]    = MDR;
        src_val[SRC_INPORT] = InPort_reg;
        src_val[SRC_C]      = C;
    end

    // Priority bus mux: scan low to high priority so the winner is written last
    always_comb begin
        bus = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_sel[i]) begin
                bus = src_val[i];
            end
        end
    end

    datapath_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .A     (Y),
        .B     (bus),
        .OP    (OP),
        .IncPC (IncPC),
        .R     (alu_r)
    );

    // Register loads with synchronous clear taking priority over every load
    always_ff @(posedge Clock) begin
        if (Clear) begin
            for (int i = 0; i < NREGS; i++) begin
                R[i] <= '0;
            end
            PC          <= '0;
            IR          <= '0;
            HI          <= '0;
            LO          <= '0;
            Y           <= '0;
            ZHigh       <= '0;
            ZLow        <= '0;
            MAR         <= '0;
            MDR         <= '0;
            C           <= '0;
            InPort_reg  <= '0;
            OutPort_reg <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (r_in[i]) begin
                    R[i] <= bus;
                end
            end
            if (PCin)    PC          <= bus;
            if (IRin)    IR          <= bus;
            if (HIin)    HI          <= bus;
            if (LOin)    LO          <= bus;
            if (Yin)     Y           <= bus;
            if (ZHighin) ZHigh       <= alu_r[2*WIDTH-1:WIDTH];
            if (ZLowin)  ZLow        <= alu_r[WIDTH-1:0];
            if (MARin)   MAR         <= bus;
            if (MDRin)   MDR         <= mdr_mux;
            if (Cin)     C           <= c_sext;
            if (OutPort) OutPort_reg <= bus;
        end
    end

`ifdef DATAPATH_DEBUG_EN
    assign BusMuxOut = bus;
    assign MAR_q     = MAR;
    assign OutPort_q = OutPort_reg;
`endif

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: stimulus pushes expected register contents
// into a scoreboard queue and a negedge monitor compares them.
module tb_datapath;

    logic        Clock;
    logic        Clear;
    logic [15:0] r_in, r_out;
    logic        PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin;
    logic        OutPort_ld, Cin, Yin;
    logic        PCout, HIout, LOout, ZHighout, ZLowout, MDRout, InPort_drv, Cout;
    logic        Read, IncPC;
    logic [31:0] Mdatain;
    logic [4:0]  OP;
`ifdef DATAPATH_DEBUG_EN
    logic [31:0] dbg_bus, dbg_mar, dbg_out;
`endif

    localparam int P_PC = 16, P_IR = 17, P_HI = 18, P_LO = 19, P_Y = 20, P_ZH = 21;
    localparam int P_ZL = 22, P_MAR = 23, P_MDR = 24, P_C = 25, P_IN = 26, P_OUT = 27;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    chk_t     sb[$];
    alu_vec_t vecs[$];
    int       n_checks = 0;
    int       n_fail   = 0;
    chk_t     cur;
    logic [31:0] act;

    datapath dut (
        .Clock(Clock), .Clear(Clear),
        .R0in(r_in[0]), .R1in(r_in[1]), .R2in(r_in[2]), .R3in(r_in[3]),
        .R4in(r_in[4]), .R5in(r_in[5]), .R6in(r_in[6]), .R7in(r_in[7]),
        .R8in(r_in[8]), .R9in(r_in[9]), .R10in(r_in[10]), .R11in(r_in[11]),
        .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
        .PCin(PCin), .IRin(IRin), .HIin(HIin), .LOin(LOin),
        .ZHighin(ZHighin), .ZLowin(ZLowin), .MARin(MARin), .MDRin(MDRin),
        .OutPort(OutPort_ld), .Cin(Cin), .Yin(Yin),
        .R0out(r_out[0]), .R1out(r_out[1]), .R2out(r_out[2]), .R3out(r_out[3]),
        .R4out(r_out[4]), .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
        .R8out(r_out[8]), .R9out(r_out[9]), .R10out(r_out[10]), .R11out(r_out[11]),
        .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
        .PCout(PCout), .HIout(HIout), .LOout(LOout), .ZHighout(ZHighout),
        .ZLowout(ZLowout), .MDRout(MDRout), .InPort(InPort_drv), .Cout(Cout),
        .Read(Read), .Mdatain(Mdatain), .IncPC(IncPC), .OP(OP)
`ifdef DATAPATH_DEBUG_EN
        , .BusMuxOut(dbg_bus), .MAR_q(dbg_mar), .OutPort_q(dbg_out)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [31:0] probe(input int s);
        case (s)
            P_PC:    return dut.PC;
            P_IR:    return dut.IR;
            P_HI:    return dut.HI;
            P_LO:    return dut.LO;
            P_Y:     return dut.Y;
            P_ZH:    return dut.ZHigh;
            P_ZL:    return dut.ZLow;
            P_MAR:   return dut.MAR;
            P_MDR:   return dut.MDR;
            P_C:     return dut.C;
            P_IN:    return dut.InPort_reg;
            P_OUT:   return dut.OutPort_reg;
            default: return dut.R[s];
        endcase
    endfunction

    // Monitor: compare every queued expectation against the settled state
    always @(negedge Clock) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            act = probe(cur.sel);
            n_checks++;
            if (act !== cur.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h", cur.name, act, cur.exp);
            end
        end
    end

    task automatic idle();
        r_in = '0; r_out = '0;
        PCin = 0; IRin = 0; HIin = 0; LOin = 0; ZHighin = 0; ZLowin = 0;
        MARin = 0; MDRin = 0; OutPort_ld = 0; Cin = 0; Yin = 0;
        PCout = 0; HIout = 0; LOout = 0; ZHighout = 0; ZLowout = 0;
        MDRout = 0; InPort_drv = 0; Cout = 0;
        Read = 0; IncPC = 0; OP = 5'b00000; Mdatain = '0;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic expect_reg(input string name, input int sel, input logic [31:0] v);
        sb.push_back('{name, sel, v});
    endtask

    task automatic mem_to_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1;
        step();
    endtask

    task automatic load_y(input logic [31:0] v);
        mem_to_mdr(v);
        MDRout = 1; Yin = 1;
        step();
    endtask

    task automatic alu_op(input logic [4:0] op, input logic [31:0] b);
        mem_to_mdr(b);
        MDRout = 1; OP = op; ZHighin = 1; ZLowin = 1;
        step();
    endtask

    initial begin
        idle();
        Clear = 1;
        step();
        Clear = 0;

        // Load many registers, then clear everything
        mem_to_mdr(32'h55);
        MDRout = 1; r_in[3] = 1; PCin = 1; IRin = 1; HIin = 1; LOin = 1;
        MARin = 1; OutPort_ld = 1; Yin = 1; IncPC = 1; ZLowin = 1; ZHighin = 1;
        step();
        Cin = 1;
        step();
        expect_reg("pre_clear_R3", 3, 32'h55);
        expect_reg("pre_clear_OutPort", P_OUT, 32'h55);
        expect_reg("pre_clear_ZLow_inc", P_ZL, 32'h56);
        expect_reg("pre_clear_C", P_C, 32'h55);
        Clear = 1;
        step();
        Clear = 0;
        for (int i = 0; i < 28; i++) begin
            expect_reg($sformatf("clear_reg%0d", i), i, 32'h0);
        end
        step();

        // Memory data through MDR into general registers
        mem_to_mdr(32'h12);
        expect_reg("mdr_12", P_MDR, 32'h12);
        MDRout = 1; r_in[0] = 1;
        step();
        expect_reg("R0_12", 0, 32'h12);
        mem_to_mdr(32'h14);
        MDRout = 1; r_in[4] = 1;
        step();
        expect_reg("R4_14", 4, 32'h14);
        mem_to_mdr(32'h18);
        MDRout = 1; r_in[5] = 1;
        step();
        expect_reg("R5_18", 5, 32'h18);

        // Instruction fetch from PC=0
        PCout = 1; MARin = 1; IncPC = 1; ZLowin = 1;
        step();
        expect_reg("fetch_MAR", P_MAR, 32'h0);
        expect_reg("fetch_ZLow", P_ZL, 32'h1);
        ZLowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h20228000;
        step();
        expect_reg("fetch_PC", P_PC, 32'h1);
        expect_reg("fetch_MDR", P_MDR, 32'h20228000);
        MDRout = 1; IRin = 1;
        step();
        expect_reg("fetch_IR", P_IR, 32'h20228000);
        Cin = 1;
        step();
        expect_reg("C_pos", P_C, 32'h00028000);
        mem_to_mdr(32'h0007FFFF);
        MDRout = 1; IRin = 1;
        step();
        Cin = 1;
        step();
        expect_reg("C_neg", P_C, 32'hFFFFFFFF);
        Cout = 1; Yin = 1;
        step();
        expect_reg("Cout_Y", P_Y, 32'hFFFFFFFF);

        // SUB R0 = R4 - R5
        r_out[4] = 1; Yin = 1;
        step();
        r_out[5] = 1; OP = 5'b00101; ZLowin = 1;
        step();
        expect_reg("sub_ZLow", P_ZL, 32'hFFFFFFFC);
        expect_reg("sub_ZHigh_kept", P_ZH, 32'h0);
        ZLowout = 1; r_in[0] = 1;
        step();
        expect_reg("sub_R0", 0, 32'hFFFFFFFC);

        // MUL and DIV, including the divide corner cases
        load_y(32'hFFFFFFFE);
        alu_op(5'b01110, 32'h3);
        expect_reg("mul_ZHigh", P_ZH, 32'hFFFFFFFF);
        expect_reg("mul_ZLow", P_ZL, 32'hFFFFFFFA);
        load_y(32'h17);
        alu_op(5'b01111, 32'h5);
        expect_reg("div_quo", P_ZL, 32'h4);
        expect_reg("div_rem", P_ZH, 32'h3);
        alu_op(5'b01111, 32'h0);
        expect_reg("div0_quo", P_ZL, 32'hFFFFFFFF);
        expect_reg("div0_rem", P_ZH, 32'h17);
        load_y(32'h80000000);
        alu_op(5'b01111, 32'hFFFFFFFF);
        expect_reg("divmin_quo", P_ZL, 32'h80000000);
        expect_reg("divmin_rem", P_ZH, 32'h0);
        load_y(32'hFFFFFFF9);
        alu_op(5'b01111, 32'h2);
        expect_reg("divneg_quo", P_ZL, 32'hFFFFFFFD);
        expect_reg("divneg_rem", P_ZH, 32'hFFFFFFFF);
        load_y(32'hFFFFFFFF);
        alu_op(5'b00011, 32'h2);
        expect_reg("add_wrap", P_ZL, 32'h1);
        expect_reg("add_ZHigh", P_ZH, 32'h0);

        // Bus priority
        mem_to_mdr(32'hAAAA);
        MDRout = 1; r_in[1] = 1;
        step();
        mem_to_mdr(32'hBBBB);
        MDRout = 1; r_in[2] = 1;
        step();
        r_out[1] = 1; r_out[2] = 1; Yin = 1;
        step();
        expect_reg("prio_R1_R2", P_Y, 32'hAAAA);
        mem_to_mdr(32'h111);
        MDRout = 1; HIin = 1;
        step();
        r_out[2] = 1; HIout = 1; Yin = 1;
        step();
        expect_reg("prio_R2_HI", P_Y, 32'hBBBB);
        mem_to_mdr(32'h222);
        MDRout = 1; LOin = 1;
        step();
        LOout = 1; PCout = 1; Cout = 1; Yin = 1;
        step();
        expect_reg("prio_LO_PC_C", P_Y, 32'h222);
        Cout = 1; MDRout = 1; Yin = 1;
        step();
        expect_reg("prio_MDR_C", P_Y, 32'h222);
        Yin = 1;
        step();
        expect_reg("bus_idle_zero", P_Y, 32'h0);

        // Shift / logic table with A = 0x80000001
        vecs.push_back('{5'b01010, 32'h1,  32'hC0000000});
        vecs.push_back('{5'b01000, 32'h1,  32'hC0000000});
        vecs.push_back('{5'b00111, 32'h1,  32'h40000000});
        vecs.push_back('{5'b00111, 32'h21, 32'h40000000});
        vecs.push_back('{5'b01001, 32'h1,  32'h00000002});
        vecs.push_back('{5'b01011, 32'h1,  32'h00000003});
        vecs.push_back('{5'b01010, 32'h0,  32'h80000001});
        vecs.push_back('{5'b01100, 32'h1,  32'h00000001});
        vecs.push_back('{5'b01101, 32'h1,  32'h80000001});
        vecs.push_back('{5'b10000, 32'h1,  32'hFFFFFFFF});
        vecs.push_back('{5'b10001, 32'h1,  32'hFFFFFFFE});
        vecs.push_back('{5'b00101, 32'h1,  32'h80000000});
        vecs.push_back('{5'b00000, 32'h1,  32'h00000000});
        vecs.push_back('{5'b11111, 32'h1,  32'h00000000});
        load_y(32'h80000001);
        for (int i = 0; i < vecs.size(); i++) begin
            alu_op(vecs[i].op, vecs[i].b);
            expect_reg($sformatf("alu_op%b_b%0h_lo", vecs[i].op, vecs[i].b), P_ZL, vecs[i].exp);
            expect_reg($sformatf("alu_op%b_b%0h_hi", vecs[i].op, vecs[i].b), P_ZH, 32'h0);
        end

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(posedge Clock);
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d checks left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
